// File: rtl/duty_seq_if.sv
// Handshake/bus bundle for duty_sequencer: PWM wrap pulse, run control,
// pattern-table write port and the duty/step/busy outputs.
interface duty_seq_if #(
   parameter int W = 8
);
   logic         period_end;
   logic         start;
   logic         stop;
   logic         wr_en;
   logic [2:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic [W-1:0] duty;
   logic [2:0]   step_idx;
   logic         busy;

   modport master (
      output period_end, start, stop, wr_en, wr_addr, wr_data,
      input  duty, step_idx, busy
   );

   modport slave (
      input  period_end, start, stop, wr_en, wr_addr, wr_data,
      output duty, step_idx, busy
   );
endinterface

// File: rtl/duty_sequencer.sv
// Steps a PWM duty word through an 8-entry pattern table, holding each entry
// for HOLD periods. Optional slew limiting is enabled by macro DUTY_SEQ_SLEW_EN.
module duty_sequencer #(
   parameter int W    = 8,
   parameter int HOLD = 16,
   parameter int SLEW = 8
) (
   input  logic       clk,
   input  logic       reset,
   duty_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      RAMPDOWN = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_C = 8'(HOLD);
`ifdef DUTY_SEQ_SLEW_EN
   localparam logic [W:0] SLEW_C = (W+1)'(SLEW);
`endif

   state_t       state_q, state_d;
   logic [W-1:0] duty_q, duty_d;
   logic [2:0]   idx_q, idx_d;
   logic [7:0]   hold_q, hold_d;
   logic         busy_q, busy_d;
   logic         rst_done_q, rst_done_d;
   logic [W-1:0] table_q [8];
   logic [W-1:0] table_d [8];
   logic [W-1:0] target_s;
   logic [W-1:0] ramp_s;
   logic [7:0]   hold_inc_s;

   // Move cur toward tgt without overshoot; bit W flags an out-of-range result.
   function automatic logic [W-1:0] approach(input logic [W-1:0] cur, input logic [W-1:0] tgt);
      logic [W:0] cur_x;
      logic [W:0] tgt_x;
      logic [W:0] gap;
      logic [W:0] stp;
      logic [W:0] nxt;
      cur_x = {1'b0, cur};
      tgt_x = {1'b0, tgt};
      if (tgt_x >= cur_x) gap = tgt_x - cur_x;
      else                gap = cur_x - tgt_x;
`ifdef DUTY_SEQ_SLEW_EN
      if (gap > SLEW_C) stp = SLEW_C;
      else              stp = gap;
`else
      stp = gap;
`endif
      if (tgt_x >= cur_x) nxt = cur_x + stp;
      else                nxt = cur_x - stp;
      return nxt[W] ? {W{1'b1}} : nxt[W-1:0];
   endfunction

   // Pattern table write; deliberately not reset.
   always_comb begin
      table_d = table_q;
      if (bus.wr_en) table_d[bus.wr_addr] = bus.wr_data;
      else           table_d[bus.wr_addr] = table_q[bus.wr_addr];
   end

   // Table storage register.
   always_ff @(posedge clk) begin
      table_q <= table_d;
   end

   // Sequencer next state; nothing advances on the first edge out of reset.
   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      rst_done_d = 1'b1;
      target_s   = table_q[idx_q];
      ramp_s     = approach(duty_q, {W{1'b0}});
      hold_inc_s = hold_q + 8'd1;
      if (rst_done_q) begin
         case (state_q)
            IDLE: begin
               duty_d = {W{1'b0}};
               if (bus.start && !bus.stop) begin
                  state_d = RUN;
                  idx_d   = 3'd0;
                  hold_d  = 8'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (bus.period_end) begin
                  // Duty uses the target in force before any step advance.
                  duty_d = approach(duty_q, target_s);
                  if (hold_inc_s == HOLD_C) begin
                     hold_d = 8'd0;
                     idx_d  = idx_q + 3'd1;
                  end else begin
                     hold_d = hold_inc_s;
                  end
               end else begin
                  duty_d = duty_q;
               end
               if (bus.stop) state_d = RAMPDOWN;
               else          state_d = RUN;
            end
            RAMPDOWN: begin
               if (bus.period_end) begin
                  duty_d = ramp_s;
                  if (ramp_s == {W{1'b0}}) state_d = IDLE;
                  else                     state_d = RAMPDOWN;
               end else begin
                  state_d = RAMPDOWN;
               end
            end
            default: begin
               state_d = IDLE;
               duty_d  = {W{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         duty_q     <= {W{1'b0}};
         idx_q      <= 3'd0;
         hold_q     <= 8'd0;
         busy_q     <= 1'b0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         busy_q     <= busy_d;
         rst_done_q <= rst_done_d;
      end
   end

   assign bus.duty     = duty_q;
   assign bus.step_idx = idx_q;
   assign bus.busy     = busy_q;

endmodule

// File: doc/duty_sequencer.md
DUTY_SEQUENCER -- requirements
Module: duty_sequencer

Interface
REQ-001 SHALL have parameter W, default 8: duty word width.
REQ-002 SHALL have parameter HOLD, default 16: PWM periods per pattern step, range 1..255.
REQ-003 SHALL have parameter SLEW, default 8: maximum duty change per PWM period, range 1..2^W-1.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port period_end, input, 1: one-cycle pulse from the downstream PWM counter wrap.
REQ-007 SHALL have port start, input, 1: level-sampled run request.
REQ-008 SHALL have port stop, input, 1: level-sampled stop request.
REQ-009 SHALL have ports wr_en, wr_addr[2:0] and wr_data[W-1:0], inputs: pattern table write port.
REQ-010 SHALL have port duty, output, W: duty word consumed by the PWM comparator.
REQ-011 SHALL have port step_idx, output, 3: index of the current target entry.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL hold an 8-entry x W pattern table, written synchronously when wr_en=1 in any state.
REQ-014 SHALL implement states IDLE, RUN and RAMPDOWN.
REQ-015 SHALL move IDLE->RUN on the cycle start=1 and stop=0; in that cycle it SHALL set step_idx=0 and clear the hold counter.
REQ-016 SHALL change duty only on cycles with period_end=1; duty SHALL be stable between pulses.
REQ-017 In RUN, at each period_end, SHALL move duty toward target=table[step_idx].
- Step size: min(|target-duty|, SLEW).
- No overshoot and no wrap.
REQ-018 In RUN, at each period_end, SHALL increment the hold counter.
- When the counter reaches HOLD: step_idx increments (7 wraps to 0) and the counter clears, on that same pulse.
- The duty update on that pulse SHALL use the old target.
REQ-019 A table write to the entry currently addressed by step_idx SHALL take effect as target from the next period_end.
REQ-020 SHALL move RUN->RAMPDOWN when stop=1; stop SHALL win over a simultaneous start.
REQ-021 In RAMPDOWN, SHALL use target 0 and apply the REQ-017 stepping at each period_end, ignoring start.
- Move to IDLE on the pulse where duty becomes 0.
- If duty is already 0, move to IDLE at the next period_end.
REQ-022 In IDLE, SHALL hold duty=0 and leave step_idx at its last value.
REQ-023 SHALL implement all arithmetic at W+1 bits to detect saturation; duty SHALL stay within 0..2^W-1.

Reset
REQ-024 SHALL, on reset=0, asynchronously force state=IDLE, duty=0, step_idx=0, hold counter=0 and busy=0, including mid-ramp.
REQ-025 Reset SHALL NOT clear the pattern table; table contents after power-up are undefined until written.
REQ-026 SHALL leave reset on the first clk edge after reset=1; any period_end coinciding with that edge SHALL be ignored.

Configuration
REQ-027 Macro DUTY_SEQ_SLEW_EN controls slew limiting.
- Defined: REQ-017 and REQ-021 stepping applies.
- Undefined: duty SHALL jump directly to target at each period_end, and RAMPDOWN SHALL exit to IDLE on its first period_end with duty=0.
- The SLEW parameter SHALL be ignored when the macro is undefined.

Verification
REQ-028 SHALL cover: table={0x40,0xC0,...}, HOLD=2, SLEW=8, start → duty 0x08,0x10,... rising by 8 per period_end; step_idx 0→1 after the 2nd pulse.
REQ-029 SHALL cover: duty=0x40, target=0x3C, SLEW=8 → duty=0x3C on the next period_end, with no overshoot.
REQ-030 SHALL cover: step_idx=7, hold counter reaches HOLD → step_idx=0 and target=table[0].
REQ-031 SHALL cover: start and stop asserted together in IDLE → stays IDLE, busy=0. In RUN with duty=0x18 and stop=1 → duty 0x10,0x08,0x00, then IDLE.
REQ-032 SHALL cover: reset pulled low mid-RAMPDOWN with duty=0x30 → duty=0 and busy=0 immediately, with no clk edge required.
REQ-033 SHALL cover: with DUTY_SEQ_SLEW_EN undefined, target 0xFF from duty 0 → duty=0xFF after one period_end.
